// File: rtl/soc_addr_map_decoder.sv
// rtl/soc_addr_map_decoder.sv - runtime-programmable address map decoder with registered valid/ready result stage
module soc_addr_map_decoder #(
    parameter int NumRules  = 10,
    parameter int AddrWidth = 64,
    parameter int IdxWidth  = $clog2(NumRules),
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstBase = {
        64'h0000_0000_0000_0000,  // 9 Debug
        64'h0000_0000_0001_0000,  // 8 ROM
        64'h0000_0000_0200_0000,  // 7 CLINT
        64'h0000_0000_0C00_0000,  // 6 PLIC
        64'h0000_0000_1000_0000,  // 5 UART
        64'h0000_0000_1800_0000,  // 4 Timer
        64'h0000_0000_2000_0000,  // 3 SPI
        64'h0000_0000_3000_0000,  // 2 Ethernet
        64'h0000_0000_4000_0000,  // 1 GPIO
        64'h0000_0000_8000_0000   // 0 DRAM
    },
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstLen = {
        64'h0000_0000_0000_1000,  // 9 Debug
        64'h0000_0000_0001_0000,  // 8 ROM
        64'h0000_0000_000C_0000,  // 7 CLINT
        64'h0000_0000_03FF_FFFF,  // 6 PLIC
        64'h0000_0000_0000_1000,  // 5 UART
        64'h0000_0000_0000_1000,  // 4 Timer
        64'h0000_0000_0080_0000,  // 3 SPI
        64'h0000_0000_0001_0000,  // 2 Ethernet
        64'h0000_0000_0000_1000,  // 1 GPIO
        64'h0000_0000_4000_0000   // 0 DRAM
    },
    parameter int CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_rule_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_err_o,
    output logic                 locked_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IdxWidth-1:0]  out_idx_o,
    output logic                 out_miss_o,
    output logic [CntWidth-1:0]  miss_cnt_o
);

    localparam logic [IdxWidth:0] NumRulesW = (IdxWidth+1)'(NumRules);

    logic [AddrWidth-1:0] rule_base [NumRules];
    logic [AddrWidth-1:0] rule_len  [NumRules];
    logic                 rule_en   [NumRules];

    logic                 rule_in_range;
    logic                 cfg_write;
    logic                 accept;
    logic                 hit_found;
    logic [IdxWidth-1:0]  hit_idx;

    assign rule_in_range = ({1'b0, cfg_rule_i} < NumRulesW);
    assign cfg_write     = cfg_we_i && !locked_o && rule_in_range;
    assign in_ready_o    = !out_valid_o || out_ready_i;
    assign accept        = in_valid_i && in_ready_o;

    // Priority match: scan upward and keep the first (lowest) hitting rule.
    // The addr >= base guard rejects addresses that only match via wraparound.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int r = 0; r < NumRules; r++) begin
            if (!hit_found && rule_en[r] && (in_addr_i >= rule_base[r]) &&
                ((in_addr_i - rule_base[r]) < rule_len[r])) begin
                hit_found = 1'b1;
                hit_idx   = IdxWidth'(r);
            end
        end
    end

    // Rule table: lookups this cycle see old values, writes land at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRules; r++) begin
                rule_base[r] <= RstBase[r];
                rule_len[r]  <= RstLen[r];
                rule_en[r]   <= 1'b1;
            end
        end else begin
            for (int r = 0; r < NumRules; r++) begin
                if (cfg_write && (cfg_rule_i == IdxWidth'(r))) begin
                    rule_base[r] <= cfg_base_i;
                    rule_len[r]  <= cfg_len_i;
                    rule_en[r]   <= cfg_en_i;
                end
            end
        end
    end

    // Sticky lock and one-cycle rejection pulse for refused writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_o  <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i && (locked_o || !rule_in_range);
            if (cfg_lock_i) begin
                locked_o <= 1'b1;
            end
        end
    end

    // Result stage: load on accept, drop valid when consumed, hold while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_idx_o   <= '0;
            out_miss_o  <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_idx_o   <= hit_idx;
            out_miss_o  <= !hit_found;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Saturating count of accepted lookups that matched no rule.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miss_cnt_o <= '0;
        end else if (accept && !hit_found && (miss_cnt_o != {CntWidth{1'b1}})) begin
            miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_soc_addr_map_decoder.sv
// tb/tb_soc_addr_map_decoder.sv - directed and randomized checks of soc_addr_map_decoder against a reference model
module tb_soc_addr_map_decoder;

    localparam int NR = 10;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int CW = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [IW-1:0] cfg_rule;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_len;
    logic          cfg_en;
    logic          cfg_lock;
    logic          cfg_err;
    logic          locked;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic          out_miss;
    logic [CW-1:0] miss_cnt;

    always #5 clk = ~clk;

    soc_addr_map_decoder #(.CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_we_i(cfg_we), .cfg_rule_i(cfg_rule), .cfg_base_i(cfg_base),
        .cfg_len_i(cfg_len), .cfg_en_i(cfg_en), .cfg_lock_i(cfg_lock),
        .cfg_err_o(cfg_err), .locked_o(locked),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_idx_o(out_idx), .out_miss_o(out_miss), .miss_cnt_o(miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] m_base [NR];
    logic [AW-1:0] m_len  [NR];
    logic          m_en   [NR];
    logic          m_locked, m_err, m_valid, m_miss;
    logic [IW-1:0] m_idx;
    int            m_cnt;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW:0] ref_lookup(input logic [AW-1:0] a);
        for (int r = 0; r < NR; r++) begin
            if (m_en[r] && a >= m_base[r] && (a - m_base[r]) < m_len[r])
                return {1'b0, IW'(r)};
        end
        return {1'b1, {IW{1'b0}}};
    endfunction

    task automatic model_reset();
        m_base[0] = 64'h8000_0000; m_len[0] = 64'h4000_0000;
        m_base[1] = 64'h4000_0000; m_len[1] = 64'h1000;
        m_base[2] = 64'h3000_0000; m_len[2] = 64'h1_0000;
        m_base[3] = 64'h2000_0000; m_len[3] = 64'h80_0000;
        m_base[4] = 64'h1800_0000; m_len[4] = 64'h1000;
        m_base[5] = 64'h1000_0000; m_len[5] = 64'h1000;
        m_base[6] = 64'h0C00_0000; m_len[6] = 64'h3FF_FFFF;
        m_base[7] = 64'h0200_0000; m_len[7] = 64'hC_0000;
        m_base[8] = 64'h1_0000;    m_len[8] = 64'h1_0000;
        m_base[9] = 64'h0;         m_len[9] = 64'h1000;
        for (int r = 0; r < NR; r++) m_en[r] = 1'b1;
        m_locked = 0; m_err = 0; m_valid = 0; m_miss = 0; m_idx = '0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("out_idx", out_idx, m_idx);
        chk("out_miss", out_miss, m_miss);
        chk("miss_cnt", miss_cnt, m_cnt);
        chk("cfg_err", cfg_err, m_err);
        chk("locked", locked, m_locked);
    endtask

    task automatic do_reset();
        rst = 1; cfg_we = 0; cfg_lock = 0; in_valid = 0; out_ready = 1;
        cfg_rule = '0; cfg_base = '0; cfg_len = '0; cfg_en = 0; in_addr = '0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        check_outputs();
    endtask

    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic rdy,
                         input logic we, input logic [IW-1:0] rule,
                         input logic [AW-1:0] b, input logic [AW-1:0] l,
                         input logic e, input logic lk);
        logic acc;
        logic [IW:0] res;
        in_valid = v; in_addr = a; out_ready = rdy;
        cfg_we = we; cfg_rule = rule; cfg_base = b; cfg_len = l; cfg_en = e; cfg_lock = lk;
        #1;
        chk("in_ready", in_ready, !m_valid || rdy);
        acc = v && (!m_valid || rdy);
        if (acc) begin
            res = ref_lookup(a);
            m_valid = 1; m_idx = res[IW-1:0]; m_miss = res[IW];
            if (m_miss && m_cnt < CNT_MAX) m_cnt++;
        end else if (rdy) begin
            m_valid = 0;
        end
        m_err = we && (m_locked || rule >= NR);
        if (we && !m_locked && rule < NR) begin
            m_base[rule] = b; m_len[rule] = l; m_en[rule] = e;
        end
        if (lk) m_locked = 1;
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic look(input logic [AW-1:0] a);
        cycle(1, a, 1, 0, '0, '0, '0, 0, 0);
    endtask

    task automatic idle();
        cycle(0, '0, 1, 0, '0, '0, '0, 0, 0);
    endtask

    initial begin
        logic [AW-1:0] a, b, l;
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_cnt", miss_cnt, 0);

        look(64'h1000_0004);
        chk("t1_valid", out_valid, 1);
        chk("t1_idx", out_idx, 5);
        chk("t1_miss", out_miss, 0);
        idle();

        look(64'h5000);
        chk("t2_idx", out_idx, 0);
        chk("t2_miss", out_miss, 1);
        chk("t2_cnt", miss_cnt, 1);
        idle();

        cycle(1, 64'h1000_0004, 1, 0, '0, '0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 64'h8000_0000, 0, 0, '0, '0, '0, 0, 0);
            chk("t3_stall_ready", in_ready, 0);
            chk("t3_stall_idx", out_idx, 5);
        end
        cycle(1, 64'h8000_0000, 1, 0, '0, '0, '0, 0, 0);
        chk("t3_b_idx", out_idx, 0);
        chk("t3_b_miss", out_miss, 0);
        cycle(1, 64'h4000_0010, 1, 0, '0, '0, '0, 0, 0);
        chk("t3_c_idx", out_idx, 1);
        idle();

        cycle(1, 64'h5000, 1, 1, 4'd5, 64'h5000, 64'h1000, 1, 0);
        chk("t4_old_miss", out_miss, 1);
        look(64'h5000);
        chk("t4_new_idx", out_idx, 5);
        chk("t4_new_miss", out_miss, 0);

        cycle(0, '0, 1, 0, '0, '0, '0, 0, 1);
        chk("t5_locked", locked, 1);
        cycle(0, '0, 1, 1, 4'd2, 64'h5000, 64'h1000, 1, 0);
        chk("t5_err", cfg_err, 1);
        look(64'h5000);
        chk("t5_err_clear", cfg_err, 0);
        chk("t5_unchanged", out_idx, 5);
        do_reset();
        cycle(0, '0, 1, 1, 4'd12, 64'h5000, 64'h1000, 1, 0);
        chk("t5_range_err", cfg_err, 1);
        chk("t5_not_locked", locked, 0);

        cycle(0, '0, 1, 1, 4'd9, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 1, 0);
        look(64'hFFFF_FFFF_FFFF_FFF0);
        chk("t6_top_idx", out_idx, 9);
        chk("t6_top_miss", out_miss, 0);
        look(64'h10);
        chk("t6_wrap_miss", out_miss, 1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = 64'($urandom_range(0, 32'h1_7FFF));
                1: a = m_base[$urandom_range(0, NR - 1)] + 64'($urandom_range(0, 32'h1100));
                2: a = {$urandom, $urandom};
                default: a = 64'hFFFF_FFFF_FFFF_0000 | 64'($urandom_range(0, 32'hFFFF));
            endcase
            b = 64'($urandom_range(0, 24)) << 12;
            l = 64'($urandom_range(0, 3)) << 12;
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, IW'($urandom_range(0, 15)), b, l,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 150) == 0);
        end

        do_reset();
        for (int i = 0; i < 40; i++) look(64'h5000);
        chk("t6_saturated", miss_cnt, CNT_MAX);
        look(64'h5000);
        chk("t6_no_wrap", miss_cnt, CNT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
